// File: rtl/serial_mag_comp_if.sv
// rtl/serial_mag_comp_if.sv - request/result bundle between a requester and the serial comparator
interface serial_mag_comp_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             more;
  logic             less;
  logic             equal;

  modport master (
    output start, a, b,
    input  busy, done, more, less, equal
  );

  modport slave (
    input  start, a, b,
    output busy, done, more, less, equal
  );
endinterface

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - MSB-first, two-bits-per-cycle unsigned magnitude comparator
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_mag_comp_if.slave   cmp
);
  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(NSLICE + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
    $error("serial_mag_comp: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             more_q, more_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             done_q, done_d;

  logic             s_more, s_less, s_eq;

  // 2-bit comparator cell: returns {more, less, equal}, exactly one bit set
  function automatic logic [2:0] slice_cmp(input logic [1:0] x, input logic [1:0] y);
    if (x > y)      return 3'b100;
    else if (x < y) return 3'b010;
    else            return 3'b001;
  endfunction

  assign {s_more, s_less, s_eq} = slice_cmp(sa_q[WIDTH-1 -: 2], sb_q[WIDTH-1 -: 2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      more_q  <= 1'b0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      more_q  <= more_d;
      less_q  <= less_d;
      equal_q <= equal_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    more_d  = more_q;
    less_d  = less_q;
    equal_d = equal_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmp.start) begin
          sa_d    = cmp.a;
          sb_d    = cmp.b;
          cnt_d   = CW'(NSLICE);
          more_d  = 1'b0;
          less_d  = 1'b0;
          equal_d = 1'b0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (s_more) begin
          more_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (s_less) begin
          less_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(1)) begin
          equal_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // Equal slice so far: bring the next lower slice into the top bits
          sa_d    = sa_q << 2;
          sb_d    = sb_q << 2;
          cnt_d   = cnt_q - CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmp.busy  = (state_q != IDLE);
  assign cmp.done  = done_q;
  assign cmp.more  = more_q;
  assign cmp.less  = less_q;
  assign cmp.equal = equal_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - randomized bench for serial_mag_comp at WIDTH 2, 8 and 16
module tb_serial_mag_comp;
  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  int          widths [3] = '{2, 8, 16};
  logic        drv_start [3];
  logic [15:0] drv_a [3];
  logic [15:0] drv_b [3];

  serial_mag_comp_if #(.WIDTH(2))  if_w2  ();
  serial_mag_comp_if #(.WIDTH(8))  if_w8  ();
  serial_mag_comp_if #(.WIDTH(16)) if_w16 ();

  assign if_w2.start  = drv_start[0];
  assign if_w2.a      = drv_a[0][1:0];
  assign if_w2.b      = drv_b[0][1:0];
  assign if_w8.start  = drv_start[1];
  assign if_w8.a      = drv_a[1][7:0];
  assign if_w8.b      = drv_b[1][7:0];
  assign if_w16.start = drv_start[2];
  assign if_w16.a     = drv_a[2];
  assign if_w16.b     = drv_b[2];

  serial_mag_comp #(.WIDTH(2))  u_w2  (.clk(clk), .rst(rst), .cmp(if_w2.slave));
  serial_mag_comp #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .cmp(if_w8.slave));
  serial_mag_comp #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .cmp(if_w16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, more, less, equal}
  function automatic logic [4:0] outs(input int idx);
    case (idx)
      0:       return {if_w2.busy,  if_w2.done,  if_w2.more,  if_w2.less,  if_w2.equal};
      1:       return {if_w8.busy,  if_w8.done,  if_w8.more,  if_w8.less,  if_w8.equal};
      default: return {if_w16.busy, if_w16.done, if_w16.more, if_w16.less, if_w16.equal};
    endcase
  endfunction

  function automatic logic [15:0] mask(input int w);
    return (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
  endfunction

  // Reference: flag from plain magnitude compare, k = first differing 2-bit slice (MSB = 1)
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                output logic [2:0] flag, output int k);
    logic [15:0] am;
    logic [15:0] bm;
    am = a & mask(w);
    bm = b & mask(w);
    flag = (am > bm) ? 3'b100 : ((am < bm) ? 3'b010 : 3'b001);
    k = w / 2;
    for (int i = w / 2; i >= 1; i--) begin
      if (((am >> (w - 2 * i)) & 16'd3) != ((bm >> (w - 2 * i)) & 16'd3)) k = i;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) check($sformatf("%s inst%0d", name, i), 32'(outs(i)), 32'd0);
  endtask

  // Called at a negedge; checks every cycle from start acceptance until back in IDLE
  task automatic run(input int idx, input logic [15:0] a, input logic [15:0] b, input bit poke);
    int          w;
    int          k;
    logic [2:0]  f;
    logic [4:0]  want;
    w = widths[idx];
    model(w, a, b, f, k);
    drv_start[idx] = 1'b1;
    drv_a[idx]     = a;
    drv_b[idx]     = b;
    for (int m = 0; m <= k + 1; m++) begin
      @(negedge clk);
      if (m == 0) begin
        drv_start[idx] = poke;
        drv_a[idx]     = poke ? 16'h0000 : 16'($urandom);
        drv_b[idx]     = poke ? 16'hFFFF : 16'($urandom);
      end else if (m == 1) begin
        drv_start[idx] = 1'b0;
      end
      if (m < k)       want = 5'b10000;
      else if (m == k) want = {2'b11, f};
      else             want = {2'b00, f};
      check($sformatf("w%0d a=%h b=%h cyc%0d", w, a & mask(w), b & mask(w), m),
            32'(outs(idx)), 32'(want));
    end
  endtask

  initial begin
    logic [2:0] f;
    int         k;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_start[i] = 1'b0;
      drv_a[i]     = '0;
      drv_b[i]     = '0;
    end

    model(8, 16'h80, 16'h7F, f, k);
    check("pin 80/7F flag", 32'(f), 32'b100);
    check("pin 80/7F k", 32'(k), 32'd1);
    model(8, 16'h24, 16'h27, f, k);
    check("pin 24/27 flag", 32'(f), 32'b010);
    check("pin 24/27 k", 32'(k), 32'd4);
    model(8, 16'h5A, 16'h5A, f, k);
    check("pin 5A/5A flag", 32'(f), 32'b001);
    check("pin 5A/5A k", 32'(k), 32'd4);
    model(8, 16'h10, 16'h01, f, k);
    check("pin 10/01 k", 32'(k), 32'd2);

    #3 rst = 1'b1;
    #1 check_all_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("after reset release");

    run(1, 16'h5A, 16'h5A, 1'b0);
    run(1, 16'h80, 16'h7F, 1'b0);
    run(1, 16'h24, 16'h27, 1'b0);
    run(1, 16'h10, 16'h01, 1'b1);
    run(1, 16'h01, 16'h02, 1'b0);

    drv_start[1] = 1'b1;
    drv_a[1]     = 16'h00;
    drv_b[1]     = 16'h00;
    @(negedge clk);
    drv_start[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("mid-op reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post-reset quiet cyc%0d", i), 32'(outs(1)), 32'd0);
    end
    run(1, 16'hFF, 16'h00, 1'b0);

    run(2, 16'h0000, 16'h0000, 1'b0);
    run(2, 16'hFFFF, 16'hFFFF, 1'b0);
    run(2, 16'h0000, 16'hFFFF, 1'b0);
    run(2, 16'h0001, 16'h0000, 1'b0);
    run(0, 16'h0, 16'h0, 1'b0);
    run(0, 16'h3, 16'h2, 1'b0);

    for (int i = 0; i < 500; i++) begin
      run(0, 16'($urandom), 16'($urandom), 1'($urandom));
      run(2, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom) ^ 16'($urandom_range(0, 3))
                                                        : 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra;
      ra = 16'($urandom);
      run(1, ra, ($urandom_range(0, 2) == 0) ? ra ^ 16'(1 << $urandom_range(0, 7)) : 16'($urandom),
          1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
